// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: word-addressed single-port data memory behind a req/ack
// handshake. An accepted request latches its operands, waits WAIT_STATES
// cycles, performs the access, then pulses ack for one cycle. Addresses
// beyond DEPTH words complete immediately with addr_err and touch nothing.
module data_ram_ctrl #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        RW,
  input  logic [31:0] address_in,
  input  logic [31:0] RAM_in,
  output logic [31:0] RAM_out,
  output logic        ack,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS_DONE,
    S_ERR_DONE
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [31:0]         ram_out_q;
  logic                do_access;

  logic [31:0] mem [DEPTH];

  // The access happens on the edge that leaves WAIT with the counter expired.
  assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);

  // Next-state and operand-latch logic.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d   = RW;
          addr_d = address_in[ADDR_W-1:0];
          data_d = RAM_in;
          if (address_in[31:ADDR_W] != '0) begin
            state_d = S_ERR_DONE;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_ACCESS_DONE;
        end
      end
      S_ACCESS_DONE, S_ERR_DONE: state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // State, counter and operand registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Storage write on the access edge of a write request.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents stay undefined until written.
    if (do_access && !rw_q) begin
      mem[addr_q] <= data_q;
    end
  end

  // Read data register: loads only on a read's access edge, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_out_q <= 32'd0;
    end else if (do_access && rw_q) begin
      ram_out_q <= mem[addr_q];
    end
  end

  assign RAM_out  = ram_out_q;
  assign busy     = (state_q != S_IDLE);
  assign ack      = (state_q == S_ACCESS_DONE) || (state_q == S_ERR_DONE);
  assign addr_err = (state_q == S_ERR_DONE);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: directed bench for data_ram_ctrl. Four instances with
// WAIT_STATES = 1, 0, 4, 15 share operand inputs but have private req lines.
// A reference memory model fills a scoreboard queue when a request is driven;
// entries are popped and compared when the DUT acknowledges.
module tb_data_ram_ctrl;

  localparam int NDUT = 4;
  localparam int WS_TAB [NDUT] = '{1, 0, 4, 15};

  typedef struct {
    logic        err;
    logic [31:0] rout;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        req_r   [NDUT];
  logic        rw_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [31:0] ram_out_w [NDUT];
  logic        ack_w     [NDUT];
  logic        busy_w    [NDUT];
  logic        err_w     [NDUT];

  logic [31:0] m_mem  [NDUT][256];
  logic [31:0] m_rout [NDUT];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_ram_ctrl #(
      .DEPTH      (256),
      .ADDR_W     (8),
      .WAIT_STATES(WS_TAB[g])
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req_r[g]),
      .RW        (rw_r),
      .address_in(addr_r),
      .RAM_in    (data_r),
      .RAM_out   (ram_out_w[g]),
      .ack       (ack_w[g]),
      .busy      (busy_w[g]),
      .addr_err  (err_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s_busy%0d", tag, d), 32'(busy_w[d]), 32'd0);
      check($sformatf("%s_ack%0d", tag, d), 32'(ack_w[d]), 32'd0);
      check($sformatf("%s_err%0d", tag, d), 32'(err_w[d]), 32'd0);
      check($sformatf("%s_rout%0d", tag, d), ram_out_w[d], 32'd0);
    end
  endtask

  // One complete access on instance d; operands are scrambled right after
  // the accept edge so a DUT that samples them late is caught.
  task automatic do_access(input int d, input logic rw, input logic [31:0] addr,
                           input logic [31:0] data, input string tag);
    exp_t e;
    exp_t p;
    logic in_rng;
    logic got = 1'b0;
    int   lat = 0;
    int   nbusy = 0;
    in_rng = (addr[31:8] == 24'd0);
    e.err  = ~in_rng;
    e.lat  = in_rng ? WS_TAB[d] + 2 : 1;
    if (in_rng && rw) m_rout[d] = m_mem[d][addr[7:0]];
    else if (in_rng)  m_mem[d][addr[7:0]] = data;
    e.rout = m_rout[d];
    sb.push_back(e);

    @(negedge clk);
    req_r[d] = 1'b1; rw_r = rw; addr_r = addr; data_r = data;
    @(negedge clk);
    req_r[d] = 1'b0; rw_r = ~rw; addr_r = ~addr; data_r = ~data;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (c > 1) @(negedge clk);
      if (busy_w[d]) nbusy++;
      if (ack_w[d]) begin
        got = 1'b1;
        lat = c;
      end
    end
    p = sb.pop_front();
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(p.lat));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(p.lat));
    check({tag, "_addr_err"}, 32'(err_w[d]), 32'(p.err));
    check({tag, "_ram_out"}, ram_out_w[d], p.rout);
    @(negedge clk);
    check({tag, "_ack_pulse"}, 32'(ack_w[d]), 32'd0);
    check({tag, "_busy_end"}, 32'(busy_w[d]), 32'd0);
  endtask

  initial begin
    int   edge_q[$];
    int   exp_edge;
    reset_n = 1'b0;
    rw_r    = 1'b0;
    addr_r  = 32'd0;
    data_r  = 32'd0;
    for (int d = 0; d < NDUT; d++) begin
      req_r[d]  = 1'b0;
      m_rout[d] = 32'd0;
    end

    // Power-on reset.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Reset mid-WAIT aborts a pending write on the WAIT_STATES=1 instance.
    do_access(0, 1'b0, 32'd5, 32'h1111_1111, "preload5");
    @(negedge clk);
    req_r[0] = 1'b1; rw_r = 1'b0; addr_r = 32'd5; data_r = 32'hDEAD_BEEF;
    @(negedge clk);
    req_r[0] = 1'b0;
    check("abort_busy_before", 32'(busy_w[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < NDUT; d++) m_rout[d] = 32'd0;
    @(negedge clk);
    check("abort_no_ack", 32'(ack_w[0]), 32'd0);
    check("abort_idle", 32'(busy_w[0]), 32'd0);
    do_access(0, 1'b1, 32'd5, 32'd0, "read5_after_abort");

    // Write then read back.
    do_access(0, 1'b0, 32'h10, 32'hCAFE_F00D, "wr10");
    do_access(0, 1'b1, 32'h10, 32'd0, "rd10");

    // First and last word, no aliasing.
    do_access(0, 1'b0, 32'd0, 32'hA5A5_A5A5, "wr0");
    do_access(0, 1'b0, 32'd255, 32'h5A5A_5A5A, "wr255");
    do_access(0, 1'b1, 32'd0, 32'd0, "rd0");
    do_access(0, 1'b1, 32'd255, 32'd0, "rd255");

    // Out-of-range accesses complete at once and disturb nothing.
    do_access(0, 1'b1, 32'h10, 32'd0, "rd10_again");
    do_access(0, 1'b1, 32'h100, 32'd0, "rd_oor");
    do_access(0, 1'b0, 32'h100, 32'hFFFF_FFFF, "wr_oor");
    do_access(0, 1'b0, 32'h8000_0000, 32'h1234_5678, "wr_oor_msb");
    do_access(0, 1'b1, 32'd0, 32'd0, "rd0_after_oor");

    // req held for 10 edges on the WAIT_STATES=0 instance, operands changing
    // every cycle: accepts at edges 0,3,6,9, acks observed after edges 1,4,7,10.
    for (int a = 0; a < 10; a++) begin
      do_access(1, 1'b0, 32'h40 + 32'(a), 32'd0, $sformatf("b2b_clr%0d", a));
    end
    edge_q = '{1, 4, 7, 10};
    for (int a = 0; a < 10; a += 3) m_mem[1][8'h40 + 8'(a)] = 32'hB000_0000 | 32'(a);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k > 0 && ack_w[1]) begin
        exp_edge = (edge_q.size() != 0) ? edge_q.pop_front() : -1;
        check("b2b_ack_edge", 32'(k - 1), 32'(exp_edge));
        check("b2b_ack_err", 32'(err_w[1]), 32'd0);
      end
      if (k < 10) begin
        req_r[1] = 1'b1;
        rw_r     = 1'b0;
        addr_r   = 32'h40 + 32'(k);
        data_r   = 32'hB000_0000 | 32'(k);
      end else begin
        req_r[1] = 1'b0;
      end
    end
    check("b2b_ack_count_left", 32'(edge_q.size()), 32'd0);
    for (int a = 0; a < 10; a++) begin
      do_access(1, 1'b1, 32'h40 + 32'(a), 32'd0, $sformatf("b2b_rd%0d", a));
    end

    // Wait-state sweep.
    do_access(1, 1'b0, 32'h77, 32'h0123_4567, "ws0_wr");
    do_access(1, 1'b1, 32'h77, 32'd0, "ws0_rd");
    do_access(2, 1'b0, 32'h33, 32'h89AB_CDEF, "ws4_wr");
    do_access(2, 1'b1, 32'h33, 32'd0, "ws4_rd");
    do_access(3, 1'b0, 32'hC3, 32'h0F0F_F0F0, "ws15_wr");
    do_access(3, 1'b1, 32'hC3, 32'd0, "ws15_rd");
    do_access(3, 1'b1, 32'hFFFF_FFFF, 32'd0, "ws15_oor");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
